// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the EX-stage forwarding / load-use hazard logic.
//   REG_AW    : register-address width
//   FWD_W     : forwarding-select width
//   FWD_*     : operand-select encodings (register file, WB, MEM)
//   REG_ZERO  : hard-wired zero register, never a valid destination
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_W  = 2;

  localparam logic [FWD_W-1:0]  FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0]  FWD_WB   = 2'b01;
  localparam logic [FWD_W-1:0]  FWD_MEM  = 2'b10;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_hazard_unit_dest_tag_reg.sv
// ---------------------------------------------------------------------------
// dest_tag_reg
// One pipeline stage of destination-tag state {valid, wreg, memread}.
// Used once for EX->MEM and once for MEM->WB.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_valid/i_wreg/i_memread : tag entering the stage
//   o_valid/o_wreg/o_memread : registered tag
// ---------------------------------------------------------------------------
module dest_tag_reg
  import mips_pkg::*;
#(
  parameter int TAG_AW = REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [TAG_AW-1:0] i_wreg,
  input  logic              i_memread,
  output logic              o_valid,
  output logic [TAG_AW-1:0] o_wreg,
  output logic              o_memread
);

  logic              r_valid;
  logic [TAG_AW-1:0] r_wreg;
  logic              r_memread;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_wreg    <= '0;
      r_memread <= 1'b0;
    end else begin
      r_valid   <= i_valid;
      r_wreg    <= i_wreg;
      r_memread <= i_memread;
    end
  end

  assign o_valid   = r_valid;
  assign o_wreg    = r_wreg;
  assign o_memread = r_memread;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Tracks destination tags of the instructions in MEM and WB, produces the
// EX operand forwarding selects and the ID-stage load-use stall request.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   ex_wreg/ex_regwrite/ex_memread : destination and controls of EX instr
//   ex_rs, ex_rt               : EX operand source registers
//   id_rs, id_rt, id_uses_rt, id_valid : ID instruction source info
//   flush                      : EX instruction is squashed
//   fwd_a, fwd_b               : 00 regfile, 01 WB, 10 MEM
//   stall                      : load-use hazard, hold PC and IF/ID
//   mem_wreg, wb_wreg, wb_regwrite : registered tag state
//   stall_cnt (HAZ_STATS_EN)   : saturating count of stall cycles
// Build option: define HAZ_STATS_EN to add the stall_cnt counter/port.
// ---------------------------------------------------------------------------
module fwd_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int FWD_W  = mips_pkg::FWD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_valid,
  input  logic              flush,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              stall,
`ifdef HAZ_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [REG_AW-1:0] mem_wreg,
  output logic [REG_AW-1:0] wb_wreg,
  output logic              wb_regwrite
);

  logic w_ex_live;
  logic w_mem_valid;
  logic w_mem_memread;
  logic w_wb_valid;
  // The WB stage shares the tag-register shape; nothing downstream needs it.
  logic w_wb_memread_unused;

  // Writes to $0 and squashed instructions enter MEM as bubbles.
  assign w_ex_live = ex_regwrite & (ex_wreg != REG_ZERO) & ~flush;

  // ---- EX -> MEM tag stage ----
  dest_tag_reg #(.TAG_AW(REG_AW)) u_mem_tag (
    .clk       (clk),
    .rst       (reset),
    .i_valid   (w_ex_live),
    .i_wreg    (ex_wreg),
    .i_memread (ex_memread & w_ex_live),
    .o_valid   (w_mem_valid),
    .o_wreg    (mem_wreg),
    .o_memread (w_mem_memread)
  );

  // ---- MEM -> WB tag stage ----
  dest_tag_reg #(.TAG_AW(REG_AW)) u_wb_tag (
    .clk       (clk),
    .rst       (reset),
    .i_valid   (w_mem_valid),
    .i_wreg    (mem_wreg),
    .i_memread (w_mem_memread),
    .o_valid   (w_wb_valid),
    .o_wreg    (wb_wreg),
    .o_memread (w_wb_memread_unused)
  );

  assign wb_regwrite = w_wb_valid;

  // Youngest producer wins; a load still in MEM has no data yet, so it is
  // skipped and the WB stage is consulted instead.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_valid,
    input logic              m_memread,
    input logic [REG_AW-1:0] m_wreg,
    input logic              b_valid,
    input logic [REG_AW-1:0] b_wreg
  );
    if (m_valid && !m_memread && (m_wreg == src)) return FWD_MEM;
    else if (b_valid && (b_wreg == src))          return FWD_WB;
    else                                          return FWD_NONE;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, w_mem_valid, w_mem_memread, mem_wreg,
                         w_wb_valid, wb_wreg);
  assign fwd_b = fwd_sel(ex_rt, w_mem_valid, w_mem_memread, mem_wreg,
                         w_wb_valid, wb_wreg);

  // Load in EX feeding the ID instruction; flush kills the load, and reset
  // holds the request low.
  assign stall = ~reset & id_valid & ex_regwrite & ex_memread &
                 (ex_wreg != REG_ZERO) & ~flush &
                 ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] ex_wreg, ex_rs, ex_rt, id_rs, id_rt;
  logic       ex_regwrite, ex_memread, id_uses_rt, id_valid, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
  logic [4:0] mem_wreg, wb_wreg;
  logic       wb_regwrite;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .ex_wreg     (ex_wreg),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_valid    (id_valid),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
`ifdef HAZ_STATS_EN
    .stall_cnt   (stall_cnt),
`endif
    .mem_wreg    (mem_wreg),
    .wb_wreg     (wb_wreg),
    .wb_regwrite (wb_regwrite)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] wreg; logic rw; logic mr;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] irs; logic [4:0] irt;
    logic urt; logic iv; logic fl;
    logic [1:0] fa; logic [1:0] fb; logic st; logic [4:0] mw; logic wrw;
  } vec_t;

  function automatic vec_t mk(
    input logic [4:0] wreg, input logic rw, input logic mr,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] irs, input logic [4:0] irt,
    input logic urt, input logic iv, input logic fl,
    input logic [1:0] fa, input logic [1:0] fb, input logic st,
    input logic [4:0] mw, input logic wrw);
    vec_t v;
    v.wreg = wreg; v.rw = rw; v.mr = mr; v.rs = rs; v.rt = rt;
    v.irs = irs; v.irt = irt; v.urt = urt; v.iv = iv; v.fl = fl;
    v.fa = fa; v.fb = fb; v.st = st; v.mw = mw; v.wrw = wrw;
    return v;
  endfunction

  task automatic drive(input logic [4:0] wreg, input logic rw, input logic mr,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] irs, input logic [4:0] irt,
                       input logic urt, input logic iv, input logic fl);
    ex_wreg = wreg; ex_regwrite = rw; ex_memread = mr; ex_rs = rs; ex_rt = rt;
    id_rs = irs; id_rt = irt; id_uses_rt = urt; id_valid = iv; flush = fl;
  endtask

  // Reference model: the last two completed EX instructions, youngest first.
  typedef struct { logic live; logic [4:0] w; logic ld; } prod_t;
  prod_t hist[$];

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (hist[0].live && !hist[0].ld && hist[0].w == src) return 2'b10;
    if (hist[1].live && hist[1].w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    prod_t z;
    z.live = 1'b0; z.w = 5'd0; z.ld = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endtask

  vec_t tbl[18];

  initial begin
    prod_t p;
    logic [1:0] efa, efb;
    logic       est;
    int         model_stalls;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //           wreg rw mr rs rt irs irt urt iv fl   fa     fb     st mw wrw
    tbl[0]  = mk(8,   1, 0, 0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = mk(0,   0, 0, 8, 0, 0,  0,  0,  0, 0, 2'b10, 2'b00, 0, 8, 0);
    tbl[2]  = mk(0,   0, 0, 0, 8, 0,  0,  0,  0, 0, 2'b00, 2'b01, 0, 0, 1);
    tbl[3]  = mk(9,   1, 0, 0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[4]  = mk(9,   1, 0, 9, 0, 0,  0,  0,  0, 0, 2'b10, 2'b00, 0, 9, 0);
    tbl[5]  = mk(0,   0, 0, 9, 9, 0,  0,  0,  0, 0, 2'b10, 2'b10, 0, 9, 1);
    tbl[6]  = mk(4,   1, 1, 0, 0, 4,  0,  0,  1, 0, 2'b00, 2'b00, 1, 0, 1);
    tbl[7]  = mk(0,   0, 0, 4, 0, 4,  0,  0,  1, 0, 2'b00, 2'b00, 0, 4, 0);
    tbl[8]  = mk(0,   0, 0, 4, 0, 0,  0,  0,  0, 0, 2'b01, 2'b00, 0, 0, 1);
    tbl[9]  = mk(0,   1, 1, 0, 0, 0,  0,  0,  1, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[10] = mk(0,   0, 0, 0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[11] = mk(7,   1, 0, 0, 0, 0,  0,  0,  0, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[12] = mk(0,   0, 0, 7, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 7, 0);
    tbl[13] = mk(5,   1, 1, 7, 0, 5,  0,  0,  1, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[14] = mk(0,   0, 0, 5, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 5, 0);
    tbl[15] = mk(6,   1, 1, 0, 0, 1,  6,  1,  1, 0, 2'b00, 2'b00, 1, 0, 0);
    tbl[16] = mk(6,   1, 1, 0, 0, 1,  6,  0,  1, 0, 2'b00, 2'b00, 0, 6, 0);
    tbl[17] = mk(6,   1, 1, 0, 0, 6,  0,  0,  0, 0, 2'b00, 2'b00, 0, 6, 1);

    // Reset state, with a stall-shaped input pattern applied.
    @(posedge clk); #1;
    drive(3, 1, 1, 3, 3, 3, 3, 1, 1, 0);
    #3;
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_fwd_b", fwd_b, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_wreg", mem_wreg, 5'd0);
    chk("rst_wb_wreg", wb_wreg, 5'd0);
    chk("rst_wb_regwrite", wb_regwrite, 1'b0);
`ifdef HAZ_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table sequence.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].wreg, tbl[i].rw, tbl[i].mr, tbl[i].rs, tbl[i].rt,
            tbl[i].irs, tbl[i].irt, tbl[i].urt, tbl[i].iv, tbl[i].fl);
      #4;
      chk($sformatf("tbl%0d_fwd_a", i), fwd_a, tbl[i].fa);
      chk($sformatf("tbl%0d_fwd_b", i), fwd_b, tbl[i].fb);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
      chk($sformatf("tbl%0d_mem_wreg", i), mem_wreg, tbl[i].mw);
      chk($sformatf("tbl%0d_wb_regwrite", i), wb_regwrite, tbl[i].wrw);
      @(posedge clk); #1;
    end
`ifdef HAZ_STATS_EN
    chk("tbl_stall_cnt", stall_cnt, 16'd2);
`endif

    // Async reset between edges with MEM and WB tags live.
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(3, 1, 1, 3, 3, 3, 3, 1, 1, 0);
    #1;
    chk("pre_rst_fwd_a", fwd_a, 2'b10);
    chk("pre_rst_wb_regwrite", wb_regwrite, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_fwd_a", fwd_a, 2'b00);
    chk("midrst_fwd_b", fwd_b, 2'b00);
    chk("midrst_wb_regwrite", wb_regwrite, 1'b0);
    chk("midrst_mem_wreg", mem_wreg, 5'd0);
    chk("midrst_stall", stall, 1'b0);
`ifdef HAZ_STATS_EN
    chk("midrst_stall_cnt", stall_cnt, 16'd0);
`endif
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    #1;
    chk("postrst_fwd_a", fwd_a, 2'b00);
    @(posedge clk); #1;
    // Three consecutive stall cycles.
    for (int i = 0; i < 3; i++) begin
      drive(5'(10 + i), 1, 1, 0, 0, 5'(10 + i), 0, 0, 1, 0);
      #3;
      chk($sformatf("stall_seq%0d", i), stall, 1'b1);
      @(posedge clk); #1;
    end
`ifdef HAZ_STATS_EN
    chk("stall_cnt_3", stall_cnt, 16'd3);
`endif

    // Randomized run against the reference model.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    model_stalls = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0));
      efa = model_fwd(ex_rs);
      efb = model_fwd(ex_rt);
      est = id_valid && ex_regwrite && ex_memread && ex_wreg != 0 && !flush &&
            (ex_wreg == id_rs || (id_uses_rt && ex_wreg == id_rt));
      #3;
      chk("rnd_fwd_a", fwd_a, efa);
      chk("rnd_fwd_b", fwd_b, efb);
      chk("rnd_stall", stall, est);
      chk("rnd_mem_wreg", mem_wreg, hist[0].w);
      chk("rnd_wb_wreg", wb_wreg, hist[1].w);
      chk("rnd_wb_regwrite", wb_regwrite, hist[1].live);
      if (est) model_stalls++;
      p.live = ex_regwrite && ex_wreg != 0 && !flush;
      p.w    = ex_wreg;
      p.ld   = ex_memread && p.live;
      @(posedge clk);
      hist.push_front(p);
      void'(hist.pop_back());
      #1;
    end
`ifdef HAZ_STATS_EN
    chk("rnd_stall_cnt", stall_cnt, 32'(model_stalls));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Consumes the 5-bit destination-register number chosen by the EX-stage RegDst 2:1 mux, together with that instruction's RegWrite/MemRead controls.
- Carries the destination tags down the pipeline through internal EX/MEM and MEM/WB tag registers.
- Produces the EX-operand forwarding selects and the ID-stage load-use stall request.
- Sits between the EX-stage RegDst mux and the ID/EX pipeline register, PC and IF/ID write-enable logic.

Parameters:
- REG_AW, 5, register-address width.
- FWD_W, 2, forwarding-select width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_wreg  in  REG_AW  destination register from the EX RegDst mux.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- ex_rs  in  REG_AW  EX operand A source register.
- ex_rt  in  REG_AW  EX operand B source register.
- id_rs  in  REG_AW  ID rs field.
- id_rt  in  REG_AW  ID rt field.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, branch).
- id_valid  in  1  ID holds a real instruction.
- flush  in  1  branch taken: the instruction now in EX is squashed.
- fwd_a  out  FWD_W  operand A select: 00 register file, 01 WB, 10 MEM.
- fwd_b  out  FWD_W  operand B select, same encoding.
- stall  out  1  hold PC and IF/ID, force a bubble into ID/EX.
- mem_wreg  out  REG_AW  registered MEM-stage destination (debug and writeback mux).
- wb_wreg  out  REG_AW  registered WB-stage destination.
- wb_regwrite  out  1  registered WB-stage write enable.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: all tag registers clear. mem_valid=0, mem_wreg=0, mem_memread=0, wb_valid=0, wb_wreg=0, wb_regwrite=0. Consequently fwd_a=fwd_b=00 and stall=0 while reset is asserted.
- Tag capture (each rising edge):
  - ex_live = ex_regwrite & (ex_wreg!=0) & !flush.
  - MEM tag <= {ex_live, ex_wreg, ex_memread & ex_live}.
  - WB tag <= MEM tag.
  - wb_regwrite = wb_valid.
- Register $0: writes to $0 are never valid, so they never forward and never stall.
- Flush:
  - The squashed EX instruction enters MEM as a bubble (valid=0).
  - Tags already in MEM and WB advance normally.
- Forwarding selects (combinational from registered tags and the ex_* sources), operand A:
  - If mem_valid & !mem_memread & mem_wreg==ex_rs, then 10.
  - Else if wb_valid & wb_wreg==ex_rs, then 01.
  - Else 00.
  - Operand B is identical using ex_rt.
  - MEM has priority over WB when both match (youngest producer wins).
  - A MEM-stage load never forwards; its data is unavailable, and the load-use stall guarantees this case never arises.
- Load-use stall (combinational):
  - stall = id_valid & ex_regwrite & ex_memread & (ex_wreg!=0) & !flush & ((ex_wreg==id_rs) | (id_uses_rt & ex_wreg==id_rt)).
  - Stall lasts exactly one cycle. The next edge moves the load to MEM; upstream zeroes the ID/EX controls, so EX then holds a bubble and stall deasserts. The dependent instruction later receives the load data via WB forwarding (01).
- Latency: forwarding selects are valid in the same cycle as ex_*. Tags lag by 1 cycle (MEM) and 2 cycles (WB).
- Simultaneous flush and stall condition: flush wins, stall=0.
- Reset mid-operation: all in-flight tags are dropped immediately. No forwarding is asserted from pre-reset instructions.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counter increments on every edge where stall=1.
  - Saturates at 16'hFFFF and clears on reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ZERO=5'd0.
  - REG_AW.
- One natural sub-module, dest_tag_reg: a single pipeline stage holding {valid, wreg, memread} with async reset. It is instantiated twice (EX->MEM and MEM->WB).
- Comparators and select priority live in the top.

Test Plan:
- Back-to-back ALU dependency: cycle 0 ex_wreg=8, regwrite=1; cycle 1 ex_rs=8 -> fwd_a=10. Cycle 2 ex_rt=8 -> fwd_b=01.
- Double producer: writes to $9 in two consecutive cycles, then ex_rs=9 -> fwd_a=10 (MEM priority), not 01.
- Load-use: ex_memread=1, ex_wreg=4, id_rs=4 -> stall=1 for one cycle. Next cycle (bubble in EX) stall=0. Following cycle, ex_rs=4 -> fwd_a=01.
- $0 target: ex_regwrite=1, ex_wreg=0, then ex_rs=0 -> fwd_a=00 and stall never asserts.
- Flush: ex_wreg=7, regwrite=1, flush=1; next cycle ex_rs=7 -> fwd_a=00 and mem_wreg valid=0. Also, a load with a matching id_rs and flush=1 -> stall=0.
- Async reset mid-stream: assert reset between edges with MEM and WB tags live -> fwd_a/fwd_b=00 and wb_regwrite=0 immediately. With HAZ_STATS_EN, stall_cnt=0; after 3 stalls stall_cnt=3.
